// File: rtl/exe_stage_mc.sv
// -----------------------------------------------------------------------------
// exe_stage_mc -- multi-cycle execute stage of the 5-stage in-order core.
//
// Sits between decode and memory. Latches one decoded instruction per
// valid/allowin handshake, computes single-cycle ALU results through `alu`,
// optionally runs an iterative radix-2 restoring divider that stalls the
// stage until its result is ready, issues one data SRAM request per memory
// instruction and exports forwarding/hazard information back to decode.
//
// Configuration macro:
//   EXE_DIV_EN  defined   -> iterative divider present (XLEN+1 cycle divides)
//               undefined -> no divider; divide ops return 0 in one cycle
//
// Parameters:
//   XLEN      datapath width, 32 or 64
//   ALU_OP_W  width of the one-hot ALU opcode (bit map in module `alu`)
//
// Ports:
//   clk, reset (synchronous, active-high), flush (drop the held instruction)
//   ds2es_valid / es_allowin      decode -> execute handshake
//   ds_*                          decoded instruction fields
//   ms_allowin / es2ms_valid      execute -> memory handshake
//   es2ms_*                       fields passed to the memory stage
//   data_sram_*                   data SRAM request (enable, byte mask, addr, data)
//   es_fwd_*                      forwarding / hazard information for decode
// -----------------------------------------------------------------------------

// One-hot ALU. Opcode bit map:
//   0 add  1 sub  2 slt  3 sltu  4 and  5 nor  6 or  7 xor
//   8 sll  9 srl  10 sra  11 lui (passes src2)
module alu #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 12
) (
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    output logic [XLEN-1:0]     result
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = src2[SH_W-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        result = '0;
        if (alu_op[0])  result |= src1 + src2;
        if (alu_op[1])  result |= src1 - src2;
        if (alu_op[2])  result |= {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
        if (alu_op[3])  result |= {{(XLEN-1){1'b0}}, src1 < src2};
        if (alu_op[4])  result |= src1 & src2;
        if (alu_op[5])  result |= ~(src1 | src2);
        if (alu_op[6])  result |= src1 | src2;
        if (alu_op[7])  result |= src1 ^ src2;
        if (alu_op[8])  result |= src1 << shamt;
        if (alu_op[9])  result |= src1 >> shamt;
        if (alu_op[10]) result |= XLEN'($signed(src1) >>> shamt);
        if (alu_op[11]) result |= src2;
    end
endmodule

module exe_stage_mc #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    // decode -> execute
    input  logic                ds2es_valid,
    output logic                es_allowin,
    input  logic [31:0]         ds_pc,
    input  logic [ALU_OP_W-1:0] ds_alu_op,
    input  logic [XLEN-1:0]     ds_src1,
    input  logic [XLEN-1:0]     ds_src2,
    input  logic [XLEN-1:0]     ds_rkd,
    input  logic [2:0]          ds_div_op,
    input  logic                ds_load,
    input  logic                ds_store,
    input  logic [1:0]          ds_mem_size,
    input  logic                ds_mem_sext,
    input  logic                ds_gr_we,
    input  logic [4:0]          ds_dest,
    // execute -> memory
    input  logic                ms_allowin,
    output logic                es2ms_valid,
    output logic [31:0]         es2ms_pc,
    output logic [XLEN-1:0]     es2ms_result,
    output logic                es2ms_res_from_mem,
    output logic                es2ms_gr_we,
    output logic [4:0]          es2ms_dest,
    output logic [1:0]          es2ms_mem_size,
    output logic                es2ms_mem_sext,
    output logic [2:0]          es2ms_addr_lo,
    // data SRAM
    output logic                data_sram_en,
    output logic [XLEN/8-1:0]   data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [XLEN-1:0]     data_sram_wdata,
    // forwarding
    output logic                es_fwd_we,
    output logic [4:0]          es_fwd_dest,
    output logic [XLEN-1:0]     es_fwd_data,
    output logic                es_fwd_pending
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    // ---------------- stage registers ----------------
    logic                es_valid;
    logic [31:0]         es_pc;
    logic [ALU_OP_W-1:0] es_alu_op;
    logic [XLEN-1:0]     es_src1, es_src2, es_rkd;
    logic [2:0]          es_div_op;   // {valid, signed, rem}
    logic                es_load, es_store, es_mem_sext, es_gr_we;
    logic [1:0]          es_mem_size;
    logic [4:0]          es_dest;

    logic                es_ready_go;
    logic                div_valid;
    logic                div_pending;
    logic [XLEN-1:0]     div_result;
    logic [XLEN-1:0]     alu_result;

    assign div_valid   = es_div_op[2];
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go & ~flush;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset || flush) es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds2es_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_pc       <= '0;
            es_alu_op   <= '0;
            es_src1     <= '0;
            es_src2     <= '0;
            es_rkd      <= '0;
            es_div_op   <= '0;
            es_load     <= 1'b0;
            es_store    <= 1'b0;
            es_mem_size <= '0;
            es_mem_sext <= 1'b0;
            es_gr_we    <= 1'b0;
            es_dest     <= '0;
        end else if (ds2es_valid && es_allowin) begin
            es_pc       <= ds_pc;
            es_alu_op   <= ds_alu_op;
            es_src1     <= ds_src1;
            es_src2     <= ds_src2;
            es_rkd      <= ds_rkd;
            es_div_op   <= ds_div_op;
            es_load     <= ds_load;
            es_store    <= ds_store;
            es_mem_size <= ds_mem_size;
            es_mem_sext <= ds_mem_sext;
            es_gr_we    <= ds_gr_we;
            es_dest     <= ds_dest;
        end
    end

    alu #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_alu (
        .alu_op (es_alu_op),
        .src1   (es_src1),
        .src2   (es_src2),
        .result (alu_result)
    );

`ifdef EXE_DIV_EN
    // ---------------- iterative restoring divider ----------------
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
    div_state_t div_state, div_next;

    logic [XLEN-1:0]  div_q;      // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0]  div_r;      // partial remainder
    logic [XLEN-1:0]  div_d;      // divisor magnitude
    logic [CNT_W-1:0] div_cnt;
    logic             div_start;
    logic             src1_neg, src2_neg, q_neg, r_neg;
    logic [XLEN:0]    rem_shift, rem_diff;

    assign div_start = (div_state == DIV_IDLE) & es_valid & div_valid & ~flush;
    assign src1_neg  = es_div_op[1] & es_src1[XLEN-1];
    assign src2_neg  = es_div_op[1] & es_src2[XLEN-1];
    // Divide by zero keeps the all-ones quotient regardless of dividend sign.
    assign q_neg     = (src1_neg ^ src2_neg) & (|es_src2);
    assign r_neg     = src1_neg;

    // One shift-subtract step; the extra top bit is the borrow of the trial subtract.
    assign rem_shift = {div_r, div_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, div_d};

    always_ff @(posedge clk) begin
        if (reset) div_state <= DIV_IDLE;
        else       div_state <= div_next;
    end

    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (div_start) div_next = DIV_BUSY;
            DIV_BUSY: if (div_cnt == CNT_W'(1)) div_next = DIV_DONE;
            DIV_DONE: if (es2ms_valid & ms_allowin) div_next = DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
        if (flush) div_next = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            div_r   <= '0;
            div_d   <= '0;
            div_cnt <= '0;
        end else if (div_start) begin
            div_q   <= src1_neg ? -es_src1 : es_src1;
            div_d   <= src2_neg ? -es_src2 : es_src2;
            div_r   <= '0;
            div_cnt <= CNT_W'(XLEN);
        end else if (div_state == DIV_BUSY) begin
            if (!rem_diff[XLEN]) begin
                div_r <= rem_diff[XLEN-1:0];
                div_q <= {div_q[XLEN-2:0], 1'b1};
            end else begin
                div_r <= rem_shift[XLEN-1:0];
                div_q <= {div_q[XLEN-2:0], 1'b0};
            end
            div_cnt <= div_cnt - CNT_W'(1);
        end
    end

    assign es_ready_go = ~div_valid | (div_state == DIV_DONE);
    assign div_pending = div_valid & (div_state != DIV_DONE);
    assign div_result  = es_div_op[0] ? (r_neg ? -div_r : div_r)
                                      : (q_neg ? -div_q : div_q);
`else
    logic div_op_unused;
    assign div_op_unused = ^es_div_op[1:0];

    assign es_ready_go = 1'b1;
    assign div_pending = 1'b0;
    assign div_result  = '0;
`endif

    // ---------------- memory-stage outputs ----------------
    assign es2ms_pc           = es_pc;
    assign es2ms_result       = div_valid ? div_result : alu_result;
    assign es2ms_res_from_mem = es_load;
    assign es2ms_gr_we        = es_gr_we;
    assign es2ms_dest         = es_dest;
    assign es2ms_mem_size     = es_mem_size;
    assign es2ms_mem_sext     = es_mem_sext;
    assign es2ms_addr_lo      = alu_result[2:0];

    // ---------------- data SRAM request ----------------
    logic [NB-1:0] size_mask;

    // Enable only on the handshake cycle so each memory op issues exactly once.
    assign data_sram_en   = es_valid & (es_load | es_store) & ms_allowin & ~flush;
    assign data_sram_addr = alu_result[31:0];

    always_comb begin
        size_mask       = '0;
        data_sram_wdata = '0;
        case (es_mem_size)
            2'd0: begin
                size_mask       = NB'(8'h01);
                data_sram_wdata = {NB{es_rkd[7:0]}};
            end
            2'd1: begin
                size_mask       = NB'(8'h03);
                data_sram_wdata = {(NB/2){es_rkd[15:0]}};
            end
            2'd2: begin
                size_mask       = NB'(8'h0F);
                data_sram_wdata = {(XLEN/32){es_rkd[31:0]}};
            end
            default: begin
                size_mask       = NB'(8'hFF);
                data_sram_wdata = es_rkd;
            end
        endcase
    end

    assign data_sram_we = (es_store & data_sram_en) ? (size_mask << alu_result[OFF_W-1:0]) : '0;

    // ---------------- forwarding ----------------
    assign es_fwd_we      = es_valid & es_gr_we;
    assign es_fwd_dest    = es_dest;
    assign es_fwd_data    = es2ms_result;
    assign es_fwd_pending = es_fwd_we & (es_load | div_pending);
endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised multi-cycle execute stage for the 5-stage in-order core, between the decode and memory stages. It latches one decoded instruction per valid/allowin handshake and computes single-cycle ALU results through the existing `alu` unit. It runs an iterative radix-2 divider that stalls the stage until the result is ready. It issues sub-word-aware data SRAM requests and exports forwarding/hazard information to decode.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be 32 or 64.
- `ALU_OP_W`, 12: width of the one-hot ALU opcode.

Ports (reset is `reset`, synchronous, active-high; clock is `clk`):
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `flush` in 1: discard the instruction held in EXE.
- `ds2es_valid` in 1: decode has an instruction.
- `es_allowin` out 1: EXE can accept it.
- `ds_pc` in 32: instruction PC.
- `ds_alu_op` in ALU_OP_W: ALU opcode.
- `ds_src1` in XLEN: operand 1.
- `ds_src2` in XLEN: operand 2.
- `ds_rkd` in XLEN: store data.
- `ds_div_op` in 3: {valid, signed, rem}.
- `ds_load` in 1: load.
- `ds_store` in 1: store.
- `ds_mem_size` in 2: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
- `ds_mem_sext` in 1: sign-extend load data.
- `ds_gr_we` in 1: register write.
- `ds_dest` in 5: destination register.
- `ms_allowin` in 1: memory stage accepts.
- `es2ms_valid` out 1: handshake valid.
- `es2ms_pc` out 32.
- `es2ms_result` out XLEN.
- `es2ms_res_from_mem` out 1.
- `es2ms_gr_we` out 1.
- `es2ms_dest` out 5.
- `es2ms_mem_size` out 2.
- `es2ms_mem_sext` out 1.
- `es2ms_addr_lo` out 3.
- `data_sram_en` out 1.
- `data_sram_we` out XLEN/8.
- `data_sram_addr` out 32.
- `data_sram_wdata` out XLEN.
- `es_fwd_we` out 1: EXE holds a register writer.
- `es_fwd_dest` out 5.
- `es_fwd_data` out XLEN.
- `es_fwd_pending` out 1: result not yet available (load, or divide not done).

## Operation
- **Latch:** input fields load into stage registers when `ds2es_valid && es_allowin`.
- **Valid bit:** `es_valid` is cleared by reset or flush. Otherwise it loads `ds2es_valid` when `es_allowin`.
- **Handshake:**
  - `es_ready_go = ~div_valid | (div_state==DONE)`.
  - `es_allowin = ~es_valid | (es_ready_go & ms_allowin)`.
  - `es2ms_valid = es_valid & es_ready_go & ~flush`.
- **Result:** `es2ms_result` is the divider output for divide ops and `alu_result` otherwise.
- **Divider FSM:**
  - IDLE -> BUSY when `es_valid & div_valid & ~flush`. On this transition it loads the magnitudes of the operands (signed ops), zeroes the remainder, and sets count to XLEN.
  - In BUSY it does one restoring shift-subtract step per cycle and decrements count. At count==1 -> DONE.
  - In DONE it applies sign fix-up: quotient negative if the operand signs differ, remainder takes the dividend's sign. DONE -> IDLE on `es2ms_valid & ms_allowin`.
  - A flush in any state -> IDLE.
- **Divide by zero:** quotient all ones, remainder = dividend. It does not shortcut; the normal latency is kept.
- **Signed MIN / -1:** quotient MIN, remainder 0, produced by the normal datapath.
- **Memory:**
  - `data_sram_en = es_valid & (load|store) & ms_allowin & ~flush`, so exactly one request is issued, on the handshake cycle.
  - `data_sram_we` is the size-wide byte mask shifted by `addr[log2(XLEN/8)-1:0]`, gated by store & `data_sram_en`.
  - `data_sram_wdata` is the low bytes of rkd replicated across the bus.
  - The address is `alu_result`. Misalignment is not checked here.
- **Forwarding:**
  - `es_fwd_we = es_valid & gr_we`.
  - `es_fwd_data = es2ms_result`.
  - `es_fwd_pending = es_fwd_we & (load | (div_valid & div_state!=DONE))`.

## Timing
- **Reset values:** `es_valid`=0, div_state=IDLE, all stage registers 0. Every output is 0 except `es_allowin`=1.
- **ALU op latency:** 1 cycle in EXE.
- **Divide latency:** latched at edge 0, IDLE -> BUSY at edge 1, DONE after XLEN BUSY cycles. `es2ms_valid` is high XLEN+1 cycles after the latch (33 for XLEN=32).
- **DONE held:** the result is held stable while `ms_allowin`=0.
- **Flush with a new instruction:** flush takes priority for the held instruction. A simultaneous new instruction is still latched when `es_allowin`, and its `es_valid` is 0 for that cycle only if flush also applies. Decode must not present an instruction in a flush cycle.
- **Back-to-back divides:** the second starts the cycle after the first's handshake.

## Configuration
- `EXE_DIV_EN` defined: the divider is present as above.
- `EXE_DIV_EN` undefined: no divider logic. `es_ready_go`=1, divide ops return 0 in one cycle, and `es_fwd_pending` covers loads only.

## Test plan
- **ADD:** ADD 5+7 with `ms_allowin`=1 -> `es2ms_valid` the next cycle, result 12, `es_allowin` held 1.
- **Signed DIV:** -7 / 2 (signed div) -> result 0xFFFFFFFD exactly 33 cycles after the latch, `es_allowin`=0 throughout. MOD of the same operands -> 0xFFFFFFFF.
- **Divide by zero:** DIVU 9 / 0 -> 0xFFFFFFFF. MODU 9 / 0 -> 9.
- **Byte store:** SB at address 0x1003 with rkd=0xAB -> `data_sram_we`=4'b1000, wdata 0xABABABAB, en high for one cycle only.
- **Back-pressure on divide:** `ms_allowin`=0 while DONE for 5 cycles -> result stable, `data_sram_en`=0, handshake on release.
- **Flush mid-divide:** flush at BUSY cycle 10 -> `es_valid`=0 next cycle, FSM IDLE. The following ADD completes in 1 cycle.
